// File: rtl/start_request_conditioner.sv
// Conditions the four raw panel buttons into one held, priority-encoded request
// with a valid/ready handshake, plus a one-cycle finish-fetch strobe.
//
// state | meaning
// IDLE  | no request held, req_valid = 0, req_code = 00
// PEND  | request held, req_valid = 1, waiting for req_ready
module start_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       start_power,
    input  logic       start_save,
    input  logic       start_fetch,
    input  logic       finish_fetch,
    output logic       req_valid,
    output logic [1:0] req_code,
    input  logic       req_ready,
    output logic       finish_pulse,
    output logic       req_dropped
);

    localparam int CH_PWR = 0;
    localparam int CH_SAV = 1;
    localparam int CH_FET = 2;
    localparam int CH_FIN = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PEND} slot_t;

    logic [3:0]            raw;
    logic [3:0]            s1, s2, db, armed, press;
    logic [3:0][CNT_W-1:0] cnt;
    logic [1:0]            fill;

    slot_t      state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       drop_q, drop_d;
    logic       fin_q, fin_d;
    logic       any_req;

    assign raw = {finish_fetch, start_fetch, start_save, start_power};

    // Arming waits for fill[1] so s2 holds a real pin sample rather than its
    // reset value; a button held through reset release must not look released.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            armed <= '0;
            press <= '0;
            fill  <= '0;
            cnt   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]    <= s2[i];
                    cnt[i]   <= '0;
                    press[i] <= s2[i] & armed[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (fill[1] && !db[i] && !s2[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign any_req = press[CH_PWR] | press[CH_SAV] | press[CH_FET];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            drop_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        drop_d  = 1'b0;
        fin_d   = press[CH_FIN];
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = PEND;
                    if (press[CH_PWR])      code_d = 2'b01;
                    else if (press[CH_SAV]) code_d = 2'b10;
                    else                    code_d = 2'b11;
                end
            end
            PEND: begin
                drop_d = any_req;
                if (req_ready) begin
                    state_d = IDLE;
                    code_d  = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = 2'b00;
            end
        endcase
    end

    assign req_valid    = (state_q == PEND);
    assign req_code     = code_q;
    assign req_dropped  = drop_q;
    assign finish_pulse = fin_q;

endmodule

// File: tb/tb_start_request_conditioner.sv
// Directed bench for start_request_conditioner with DEBOUNCE_CYCLES = 4.
module tb_start_request_conditioner;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       start_power, start_save, start_fetch, finish_fetch;
    logic       req_valid;
    logic [1:0] req_code;
    logic       req_ready;
    logic       finish_pulse;
    logic       req_dropped;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit       p, s, f, ff, rdy;
        bit       ev;
        bit [1:0] ec;
        bit       efin, edrop;
    } vec_t;

    vec_t vecs[$];

    start_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .start_power (start_power),
        .start_save  (start_save),
        .start_fetch (start_fetch),
        .finish_fetch(finish_fetch),
        .req_valid   (req_valid),
        .req_code    (req_code),
        .req_ready   (req_ready),
        .finish_pulse(finish_pulse),
        .req_dropped (req_dropped)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(bit p, bit s, bit f, bit ff, bit rdy,
                                bit ev, bit [1:0] ec, bit efin, bit edrop);
        vec_t v;
        v.p = p; v.s = s; v.f = f; v.ff = ff; v.rdy = rdy;
        v.ev = ev; v.ec = ec; v.efin = efin; v.edrop = edrop;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(int n);
        for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction

    task automatic check(string name, logic [4:0] exp);
        logic [4:0] act;
        act = {req_valid, req_code, finish_pulse, req_dropped};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {valid,code,fin,drop}=%b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start_power = 0; start_save = 0; start_fetch = 0; finish_fetch = 0;
        req_ready = 0;

        // clean save press, accept, release
        for (int i = 0; i < 20; i++) add(0, 1, 0, 0, 0, i >= 6, (i >= 6) ? 2'b10 : 2'b00, 0, 0);
        add(0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        add_idle(12);
        // 3-cycle glitch rejected, then a real power press
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add_idle(8);
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 0, i >= 6, (i >= 6) ? 2'b01 : 2'b00, 0, 0);
        add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add_idle(12);
        // power+fetch together, then save pressed while pending
        for (int i = 0; i < 16; i++)
            add(1, i >= 8, 1, 0, 0, i >= 6, (i >= 6) ? 2'b01 : 2'b00, 0, i == 14);
        add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add_idle(12);
        // two finish presses while a request is pending
        for (int i = 0; i < 34; i++)
            add(1, 0, 0, (i >= 8 && i < 14) || (i >= 24 && i < 30), 0,
                i >= 6, (i >= 6) ? 2'b01 : 2'b00, (i == 14) || (i == 30), 0);
        add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add_idle(12);
        // fetch alone
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, i >= 6, (i >= 6) ? 2'b11 : 2'b00, 0, 0);
        add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add_idle(12);

        repeat (3) step();
        check("reset_state", 5'b0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("idle_after_reset", 5'b0);
        end

        foreach (vecs[i]) begin
            start_power  = vecs[i].p;
            start_save   = vecs[i].s;
            start_fetch  = vecs[i].f;
            finish_fetch = vecs[i].ff;
            req_ready    = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i),
                  {vecs[i].ev, vecs[i].ec, vecs[i].efin, vecs[i].edrop});
        end

        // power held high across reset release must not produce a request
        rst = 1'b1;
        start_power = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("held_through_reset", 5'b0);
        end
        start_power = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("release_after_reset", 5'b0);
        end
        start_power = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("repress_%0d", k), (k >= 6) ? 5'b10100 : 5'b0);
        end

        // asynchronous reset while pending
        rst = 1'b1;
        #1;
        check("async_reset_mid_pend", 5'b0);
        start_power = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("no_req_after_reset", 5'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/start_request_conditioner.md
Name: start_request_conditioner

Overview:
- Front-end stage directly upstream of the mode state machine in the Mujica top level.
- Takes the four raw, asynchronous panel inputs: power, save, fetch, finish-fetch.
- Synchronises and debounces each input, then detects rising edges.
- Priority-encodes power/save/fetch into a single held 2-bit request with a valid/ready handshake, and emits finish-fetch as a one-cycle pulse.
- Replaces the level/edge-mixed input capture with clean single-clock logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles an input must stay at a new level before it is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; DEBOUNCE_CYCLES must be < 2^CNT_W.

Ports:
- sys_clk  in  1  50 MHz system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_power  in  1  raw power button, async.
- start_save  in  1  raw save button, async.
- start_fetch  in  1  raw fetch button, async.
- finish_fetch  in  1  raw finish-fetch button, async.
- req_valid  out  1  request pending.
- req_code  out  2  01 = power, 10 = save, 11 = fetch; 00 when not valid.
- req_ready  in  1  consumer accepts the request (high only in its IDLE state).
- finish_pulse  out  1  one-cycle strobe per accepted finish_fetch press.
- req_dropped  out  1  one-cycle strobe when a press is discarded.

Behaviour:
- Reset: all synchroniser flops, debounced levels and counters are 0; armed bits are 0; slot is IDLE; every output is 0.
- Reset mid-operation clears a pending request without it being delivered.
- Synchroniser: two flops per input (s1, s2).
- Debounce, per channel:
  - Counter clears whenever s2 == db.
  - Counter increments while s2 != db.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 != db still holds: db <= s2, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Arming, per channel:
  - armed <= 1 when db == 0 and s2 == 0.
  - A commit of db 0->1 while armed == 1 is a press strobe (internal, same cycle as the commit).
  - A commit while armed == 0 is ignored, so an input held high through reset release produces no press.
- Latency: a clean pin rise held steady gives a press strobe on the clock edge DEBOUNCE_CYCLES+2 after the first edge that samples it high. req_valid or finish_pulse is registered one edge later, at DEBOUNCE_CYCLES+3.
- Request slot FSM, two states:
  - IDLE: req_valid=0, req_code=00. On any press strobe of power/save/fetch, go to PEND and load req_code by priority power > save > fetch. Simultaneous strobes take the highest priority; the lower ones are discarded silently (not counted as dropped).
  - PEND: req_valid=1, req_code held stable. If req_ready=1, return to IDLE next cycle and clear req_code to 00.
  - Any power/save/fetch press strobe while in PEND, including the cycle where req_ready is high, is discarded and pulses req_dropped for one cycle.
- finish_fetch path: independent of the slot. Each press strobe gives finish_pulse=1 for exactly one cycle. It is never dropped and never sets req_dropped.
- Counters saturate by construction: they reset at the commit point, so no wrap is possible.
- req_ready while IDLE has no effect.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Clean press: start_save rises and is held 20 cycles with req_ready=0 -> req_valid=1, req_code=10 from edge 7 onward. Then req_ready=1 for one cycle -> req_valid=0, req_code=00 next cycle. Releasing the button produces no new request.
- Glitch rejection: start_power pulses high for 3 cycles, then low -> req_valid stays 0 throughout. Holding it high for 4+ cycles -> req_code=01.
- Priority: start_fetch and start_power rise on the same edge -> req_code=01, req_dropped stays 0. Holding req_ready=0 and pressing start_save again -> req_dropped pulses once, req_code stays 01.
- Finish path: two separated finish_fetch presses while a request is PEND -> exactly two 1-cycle finish_pulse strobes; req_valid is unaffected.
- Reset behaviour: start_power held high across rst deassertion -> no request. Release for 6 cycles, then press again -> req_code=01.
- Reset mid-PEND: rst asserted with req_valid=1 -> req_valid and req_code are 0 asynchronously; no request after rst release while all inputs stay low.
